// File: rtl/i2s_transmit_24.sv
// I2S transmitter: takes one stereo pair per frame on a valid/ready handshake and
// serialises it MSB-first in standard I2S timing (MSB one SCK after the WS change).
// SCK and WS arrive as plain signals in the clk_i domain; all slot activity happens
// in the single clk_i cycle that follows an SCK falling edge.
module i2s_transmit_24 #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic [DATA_W-1:0] left_i,
    input  logic [DATA_W-1:0] right_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              sd_o,
    output logic              underrun_o,
    output logic [CNT_W-1:0]  underrun_count_o
);

    localparam int PAD_W = SLOT_W - DATA_W;

    logic              sck_q;
    logic              ws_fall_q;
    logic [SLOT_W-1:0] shift_q;
    logic [DATA_W-1:0] right_q;
    logic [DATA_W-1:0] hold_left_q;
    logic [DATA_W-1:0] hold_right_q;
    logic              ready_q;
    logic              sd_q;
    logic              underrun_q;
    logic [CNT_W-1:0]  cnt_q;

    logic fall;
    logic trans;
    logic left_start;
    logic right_start;
    logic accept;
    logic consume;
    logic starve;

    // The channel is tracked only by the WS value seen on the previous SCK fall,
    // so any WS change (even a glitch) restarts a slot.
    assign fall        = sck_q & ~sck_i;
    assign trans       = fall & (ws_i != ws_fall_q);
    assign left_start  = trans & ~ws_i;
    assign right_start = trans & ws_i;
    // ready_q doubles as "holding register empty".
    assign accept      = valid_i & ready_q;
    // A left start samples the holding register before this cycle's accept lands,
    // so a pair offered in that very cycle waits for the next frame.
    assign consume     = left_start & ~ready_q;
    assign starve      = left_start & ready_q;

    assign ready_o          = ready_q;
    assign sd_o             = sd_q;
    assign underrun_o       = underrun_q;
    assign underrun_count_o = cnt_q;

    // SCK edge detector: previous SCK level sampled every clk.
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_q <= 1'b0;
        end else begin
            sck_q <= sck_i;
        end
    end

    // Serialiser: on each SCK fall emit the MSB, then reload on a slot start or shift.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ws_fall_q <= 1'b1;
            sd_q      <= 1'b0;
            shift_q   <= '0;
            right_q   <= '0;
        end else if (fall) begin
            ws_fall_q <= ws_i;
            sd_q      <= shift_q[SLOT_W-1];
            if (left_start) begin
                if (consume) begin
                    shift_q <= {hold_left_q, {PAD_W{1'b0}}};
                    right_q <= hold_right_q;
                end else begin
                    shift_q <= '0;
                    right_q <= '0;
                end
            end else if (right_start) begin
                shift_q <= {right_q, {PAD_W{1'b0}}};
            end else begin
                shift_q <= shift_q << 1;
            end
        end
    end

    // Holding register: fills on a handshake, empties when a left slot takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q      <= 1'b1;
            hold_left_q  <= '0;
            hold_right_q <= '0;
        end else if (accept) begin
            ready_q      <= 1'b0;
            hold_left_q  <= left_i;
            hold_right_q <= right_i;
        end else if (consume) begin
            ready_q <= 1'b1;
        end
    end

    // Underrun pulse and saturating underrun counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underrun_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            underrun_q <= starve;
            if (starve && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmit_24.sv
// Testbench for i2s_transmit_24: drives SCK/WS (4 clk per SCK, 32 SCK per slot),
// offers stereo pairs at random points in each frame and checks the serial stream,
// handshake and underrun reporting against a frame-level reference model.
// A second instance with a 3-bit counter and no traffic checks counter saturation.
module tb_i2s_transmit_24;

    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;
    localparam int CNT_W  = 16;
    localparam int SAT_W  = 3;
    localparam int N_FRAMES = 24;
    localparam int MAX_STEPS = 40000;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              sck = 1'b0;
    logic              ws = 1'b1;
    logic [DATA_W-1:0] left = '0;
    logic [DATA_W-1:0] right = '0;
    logic              valid = 1'b0;
    logic              valid_sat = 1'b0;

    logic              ready;
    logic              sd;
    logic              underrun;
    logic [CNT_W-1:0]  ucnt;
    logic              ready_s;
    logic              sd_s;
    logic              underrun_s;
    logic [SAT_W-1:0]  ucnt_s;

    int n_tests = 0;
    int n_fail  = 0;
    int uru_hi  = 0;

    always #5 clk = ~clk;

    i2s_transmit_24 #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .CNT_W(CNT_W)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .sck_i            (sck),
        .ws_i             (ws),
        .left_i           (left),
        .right_i          (right),
        .valid_i          (valid),
        .ready_o          (ready),
        .sd_o             (sd),
        .underrun_o       (underrun),
        .underrun_count_o (ucnt)
    );

    i2s_transmit_24 #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .CNT_W(SAT_W)) dut_sat (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .sck_i            (sck),
        .ws_i             (ws),
        .left_i           (left),
        .right_i          (right),
        .valid_i          (valid_sat),
        .ready_o          (ready_s),
        .sd_o             (sd_s),
        .underrun_o       (underrun_s),
        .underrun_count_o (ucnt_s)
    );

    // Count clk cycles with the underrun pulse high; each underrun must give exactly one.
    always @(negedge clk) begin
        if (underrun === 1'b1) uru_hi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state (frame level).
    bit                m_full = 1'b0;
    logic [DATA_W-1:0] m_l = '0;
    logic [DATA_W-1:0] m_r = '0;
    logic [DATA_W-1:0] cur_r = '0;
    int                m_cnt = 0;
    int                m_under = 0;
    int                m_sat_ls = 0;
    logic [31:0]       cap = '0;
    logic [31:0]       slot_exp = '0;
    bit                cap_valid = 1'b0;

    // Generator state.
    int ph = 0;
    int bitcnt = 20;
    int fr = -1;
    int fpos = 0;
    int offer_pos = -1;
    logic [DATA_W-1:0] o_l = '0;
    logic [DATA_W-1:0] o_r = '0;
    bit in_reset = 1'b0;
    bit release_next = 1'b0;
    bit reset_done = 1'b0;
    int steps = 0;

    function automatic int sat_exp(input int n);
        return (n > 7) ? 7 : n;
    endfunction

    // Choose what (if anything) to offer during frame f, for transmission in frame f+1.
    task automatic plan_frame(input int f);
        offer_pos = $urandom_range(1, 60);
        if (offer_pos == 32) offer_pos = 33;
        o_l = DATA_W'($urandom);
        o_r = DATA_W'($urandom);
        if (f <= 1 || f == 8 || f == 14) begin
            offer_pos = -1;
        end else if (f == 2) begin
            o_l = 24'hA5A5A5; o_r = 24'h3C3C3C;
        end else if (f == 3) begin
            o_l = 24'h800000; o_r = 24'h7FFFFF;
        end else if (f >= 4 && f <= 7) begin
            o_l = DATA_W'(2 * (f - 4) + 1);
            o_r = DATA_W'(2 * (f - 4) + 2);
        end else if (f >= 15 && $urandom_range(0, 3) == 0) begin
            offer_pos = -1;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", ready, 1'b1);
        check("reset_sd", sd, 1'b0);
        check("reset_underrun", underrun, 1'b0);
        check("reset_count", ucnt, '0);
        @(negedge clk);
        rst_ni = 1'b1;

        while (fr < N_FRAMES && steps < MAX_STEPS) begin
            @(negedge clk);
            steps++;
            valid = 1'b0;
            left  = DATA_W'($urandom);
            right = DATA_W'($urandom);
            if (release_next) begin
                rst_ni = 1'b1;
                release_next = 1'b0;
                in_reset = 1'b0;
            end
            ph = (ph + 1) % 4;

            if (ph == 0) begin
                // SCK rising edge: receiver's sampling point.
                sck = 1'b1;
                cap = {cap[30:0], sd};
                check("ready", ready, !m_full);
                check("count", ucnt, m_cnt);
                check("sat_count", ucnt_s, sat_exp(m_sat_ls));
                check("sat_sd", sd_s, 1'b0);
            end else if (ph == 1) begin
                if (fr == 14 && !reset_done && fpos == 10) begin
                    reset_done = 1'b1;
                    rst_ni = 1'b0;
                    #1;
                    check("rst_mid_sd", sd, 1'b0);
                    check("rst_mid_ready", ready, 1'b1);
                    check("rst_mid_underrun", underrun, 1'b0);
                    check("rst_mid_count", ucnt, '0);
                    in_reset = 1'b1;
                    m_full = 1'b0;
                    cur_r = '0;
                    m_cnt = 0;
                    m_sat_ls = 0;
                    cap_valid = 1'b0;
                end
            end else if (ph == 2) begin
                // SCK falling edge; WS changes here at slot boundaries.
                sck = 1'b0;
                bitcnt++;
                fpos++;
                if (bitcnt == SLOT_W) begin
                    bitcnt = 0;
                    ws = ~ws;
                    if (cap_valid) check($sformatf("slot_f%0d_ws%0d", fr, ~ws), cap, slot_exp);
                    cap = '0;
                    if (in_reset) begin
                        cap_valid = 1'b0;
                        release_next = 1'b1;
                    end else if (ws == 1'b0) begin
                        fr++;
                        fpos = 0;
                        if (m_full) begin
                            slot_exp = {1'b0, m_l, 7'b0};
                            cur_r = m_r;
                            m_full = 1'b0;
                        end else begin
                            slot_exp = '0;
                            cur_r = '0;
                            m_under++;
                            if (m_cnt < 65535) m_cnt++;
                        end
                        m_sat_ls++;
                        cap_valid = 1'b1;
                        plan_frame(fr);
                        if (fr == 9) begin
                            // Pair offered in the same clk as the left start.
                            left = 24'h123456;
                            right = 24'h654321;
                            valid = 1'b1;
                            m_full = 1'b1;
                            m_l = 24'h123456;
                            m_r = 24'h654321;
                        end
                    end else begin
                        slot_exp = {1'b0, cur_r, 7'b0};
                    end
                end else if (!in_reset && fpos == offer_pos) begin
                    left = o_l;
                    right = o_r;
                    valid = 1'b1;
                    if (!m_full) begin
                        m_full = 1'b1;
                        m_l = o_l;
                        m_r = o_r;
                    end
                end
            end else begin
                sck = 1'b0;
            end
        end

        if (fr < N_FRAMES) check("step_budget", fr, N_FRAMES);
        @(negedge clk);
        #1;
        check("underrun_pulses", uru_hi, m_under);
        check("final_count", ucnt, m_cnt);
        check("final_sat_count", ucnt_s, sat_exp(m_sat_ls));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
